// File: rtl/mem_pkg.sv
// Shared types for the memory request arbiter: FSM states, grant owner and
// the byte-offset width that separates a word address from a byte address.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef enum logic {GNT_I, GNT_D} grant_t;

  localparam int WORD_OFFSET_W = 2;

endpackage

// File: rtl/mem_req_arbiter_lat_counter.sv
// Loadable down-counter with a zero flag; tracks how many cycles remain
// before RAM read data becomes valid.
module lat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load takes priority; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one fixed-latency RAM
// port, returning registered read data with one-cycle ready pulses.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_ready,
  input  logic                  d_ren,
  input  logic                  d_wen,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_be,
  output logic                  ram_ren,
  output logic                  ram_wen,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  grant_t            gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic              misal_q, misal_d;
  logic              last_d_q, last_d_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [BE_W-1:0]   ram_be_q, ram_be_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              d_err_q, d_err_d;

  logic              take_d, take_wr, cnt_zero;
  logic [ADDR_W-1:0] sel_addr;

  lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == ISSUE),
    .load_val_i (CNT_W'(LATENCY - 1)),
    .dec_i      (state_q == WAIT),
    .zero_o     (cnt_zero)
  );

  // Data wins unless it was served last and a fetch is also waiting.
  assign take_d   = (d_ren | d_wen) && !(last_d_q && i_req);
  assign take_wr  = take_d && d_wen;
  assign sel_addr = take_d ? d_addr : i_addr;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    wr_d        = wr_q;
    misal_d     = misal_q;
    last_d_d    = last_d_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    ram_ren_d   = 1'b0;
    ram_wen_d   = 1'b0;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    d_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (take_d || i_req) begin
          state_d     = ISSUE;
          gnt_d       = take_d ? GNT_D : GNT_I;
          wr_d        = take_wr;
          misal_d     = take_d && (sel_addr[WORD_OFFSET_W-1:0] != '0);
          ram_addr_d  = {sel_addr[ADDR_W-1:WORD_OFFSET_W], {WORD_OFFSET_W{1'b0}}};
          ram_wdata_d = d_wdata;
          ram_be_d    = take_wr ? d_be : {BE_W{1'b1}};
          ram_ren_d   = !take_wr;
          ram_wen_d   = take_wr;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = RESP;
          if (gnt_q == GNT_I) begin
            i_rdata_d = ram_rdata;
          end else if (!wr_q) begin
            d_rdata_d = ram_rdata;
          end
          i_ready_d = (gnt_q == GNT_I);
          d_ready_d = (gnt_q == GNT_D);
          d_err_d   = (gnt_q == GNT_D) && misal_q;
        end
      end
      RESP: begin
        state_d  = IDLE;
        last_d_d = (gnt_q == GNT_D);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      wr_q        <= 1'b0;
      misal_q     <= 1'b0;
      last_d_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      misal_q     <= misal_d;
      last_d_q    <= last_d_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_be    = ram_be_q;
  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed vector table, corner-case sequences
// and randomized traffic against a transaction-level reference model.
module tb_mem_req_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mem_init;
  logic          i_req, d_ren, d_wen;
  logic [AW-1:0] i_addr, d_addr, ram_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [BW-1:0] d_be, ram_be;
  logic          i_ready, d_ready, d_err, ram_ren, ram_wen;

  logic          i_req1, i_ready1, d_ready1, d_err1, ram_ren1, ram_wen1;
  logic [AW-1:0] i_addr1, ram_addr1;
  logic [DW-1:0] i_rdata1, d_rdata1, ram_wdata1;
  logic [BW-1:0] ram_be1;
  logic [DW-1:0] ram_rdata1 = 32'h0BAD_F00D;

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ready(i_ready1),
    .d_ren(1'b0), .d_wen(1'b0), .d_addr('0), .d_wdata('0), .d_be('0),
    .d_rdata(d_rdata1), .d_ready(d_ready1), .d_err(d_err1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_be(ram_be1),
    .ram_ren(ram_ren1), .ram_wen(ram_wen1), .ram_rdata(ram_rdata1)
  );

  function automatic logic [DW-1:0] pat(input int k);
    return (k == 4) ? 32'h0050_0093 : (32'hC0DE_0000 | DW'(k));
  endfunction

  // RAM behaviour: data appears LAT cycles after the strobe cycle, noise otherwise
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] pipe [LAT];
  assign ram_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= ram_ren ? ram_mem[ram_addr[9:2]] : DW'($urandom);
    if (mem_init) begin
      for (int k = 0; k < 256; k++) ram_mem[k] <= pat(k);
    end else if (ram_wen) begin
      for (int b = 0; b < BW; b++)
        if (ram_be[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] ref_mem [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be);
    i_req = ir; i_addr = ia; d_ren = dr; d_wen = dw; d_addr = da; d_wdata = wd; d_be = be;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    for (int b = 0; b < BW; b++)
      if (be[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_addr"},  ram_addr, '0);
    chk({tag, "_ram_wdata"}, ram_wdata, '0);
    chk({tag, "_ram_be"},    32'(ram_be), '0);
    chk({tag, "_ram_ren"},   32'(ram_ren), '0);
    chk({tag, "_ram_wen"},   32'(ram_wen), '0);
    chk({tag, "_i_rdata"},   i_rdata, '0);
    chk({tag, "_d_rdata"},   d_rdata, '0);
    chk({tag, "_i_ready"},   32'(i_ready), '0);
    chk({tag, "_d_ready"},   32'(d_ready), '0);
    chk({tag, "_d_err"},     32'(d_err), '0);
  endtask

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dw; logic [31:0] da; logic [31:0] wd; logic [3:0] be;
    logic [31:0] e_addr; logic e_ren; logic e_wen; logic [3:0] e_be;
    logic        e_iry; logic e_dry; logic e_err; logic [31:0] e_rdata;
  } vec_t;

  vec_t vt [10];

  logic        last_d;
  logic [31:0] exp_i_rd, exp_d_rd;

  initial begin
    vt[0] = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 32'h10,  1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0050_0093};
    vt[1] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 32'hDEADBEEF,  4'h3, 32'h104, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h104, 32'h0,         4'h0, 32'h104, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hC0DE_BEEF};
    vt[3] = '{1'b1, 32'h20,  1'b1, 1'b0, 32'h30,  32'h0,         4'h0, 32'h20,  1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'hC0DE_0008};
    vt[4] = '{1'b1, 32'h24,  1'b1, 1'b0, 32'h30,  32'h0,         4'h0, 32'h30,  1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hC0DE_000C};
    vt[5] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h106, 32'h0,         4'h0, 32'h104, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 32'hC0DE_BEEF};
    vt[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  32'h12345678,  4'hF, 32'h40,  1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 32'hC0DE_BEEF};
    vt[7] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h40,  32'h0,         4'h0, 32'h40,  1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
    vt[8] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h43,  32'hAABBCCDD,  4'hC, 32'h40,  1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 32'h1234_5678};
    vt[9] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 32'h40,  1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'hAABB_5678};

    for (int k = 0; k < 256; k++) ref_mem[k] = pat(k);
    rst = 1'b1; mem_init = 1'b1; i_req1 = 1'b0; i_addr1 = '0;
    idle_in();
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0; mem_init = 1'b0;
    tick();

    // Directed vectors, each from IDLE: strobe in cycle 1, response in cycle 4
    for (int v = 0; v < 10; v++) begin
      drive(vt[v].ir, vt[v].ia, vt[v].dr, vt[v].dw, vt[v].da, vt[v].wd, vt[v].be);
      tick();
      chk($sformatf("v%0d_ram_addr", v), ram_addr, vt[v].e_addr);
      chk($sformatf("v%0d_ram_ren", v), 32'(ram_ren), 32'(vt[v].e_ren));
      chk($sformatf("v%0d_ram_wen", v), 32'(ram_wen), 32'(vt[v].e_wen));
      chk($sformatf("v%0d_ram_be", v), 32'(ram_be), 32'(vt[v].e_be));
      if (vt[v].e_wen) chk($sformatf("v%0d_ram_wdata", v), ram_wdata, vt[v].wd);
      tick();
      chk($sformatf("v%0d_strobe_off", v), 32'({ram_ren, ram_wen}), 32'h0);
      tick();
      chk($sformatf("v%0d_early_ready", v), 32'({i_ready, d_ready}), 32'h0);
      tick();
      chk($sformatf("v%0d_i_ready", v), 32'(i_ready), 32'(vt[v].e_iry));
      chk($sformatf("v%0d_d_ready", v), 32'(d_ready), 32'(vt[v].e_dry));
      chk($sformatf("v%0d_d_err", v), 32'(d_err), 32'(vt[v].e_err));
      chk($sformatf("v%0d_rdata", v), vt[v].e_iry ? i_rdata : d_rdata, vt[v].e_rdata);
      if (vt[v].dw) ref_write(vt[v].da, vt[v].wd, vt[v].be);
      idle_in();
      tick();
      chk($sformatf("v%0d_pulse_end", v), 32'({i_ready, d_ready, d_err}), 32'h0);
    end

    // Both requesters held: data first, then fetch, then data again
    drive(1'b1, 32'h50, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("alt_c%0d_i_ready", k), 32'(i_ready), 32'(k == 9));
      chk($sformatf("alt_c%0d_d_ready", k), 32'(d_ready), 32'(k == 4 || k == 14));
      if (k == 4 || k == 14) chk($sformatf("alt_c%0d_d_rdata", k), d_rdata, ref_mem[8'h18]);
      if (k == 9) chk("alt_i_rdata", i_rdata, ref_mem[8'h14]);
    end
    idle_in();
    tick();

    // Reset landing in the WAIT cycle of a fetch
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("rstw_ren", 32'(ram_ren), 32'h1);
    tick();
    rst = 1'b1;
    idle_in();
    tick();
    chk_all_zero("rstw");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rstw_quiet%0d", k), 32'({i_ready, ram_ren, ram_wen}), 32'h0);
    end

    // Single-cycle-latency build: fetch completes 3 cycles after the request edge
    i_req1 = 1'b1; i_addr1 = 32'h80;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("lat1_c%0d_i_ready", k), 32'(i_ready1), 32'(k == 3));
      if (k == 1) chk("lat1_ram_addr", ram_addr1, 32'h80);
      if (k == 1) chk("lat1_ram_ren", 32'(ram_ren1), 32'h1);
      if (k == 3) begin
        chk("lat1_i_rdata", i_rdata1, 32'h0BAD_F00D);
        i_req1 = 1'b0;
      end
    end

    // Randomized traffic against the transaction-level model
    last_d = 1'b0; exp_i_rd = '0; exp_d_rd = '0;
    for (int t = 0; t < 60; t++) begin
      logic ir, dr, dw, want_d;
      logic [31:0] ia, da, wd;
      logic [3:0] be;
      int kind, waited;
      ir   = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      if (!ir && kind == 0) ir = 1'b1;
      dr = (kind == 1 || kind == 3);
      dw = (kind >= 2);
      ia = 32'($urandom_range(0, 255)) << 2;
      da = 32'($urandom_range(0, 1023));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      drive(ir, ia, dr, dw, da, wd, be);
      want_d = (dr || dw) && !(last_d && ir);
      waited = 0;
      for (int k = 1; k <= 12; k++) begin
        tick();
        waited = k;
        if (i_ready || d_ready) break;
      end
      chk($sformatf("rnd%0d_latency", t), 32'(waited), 32'(LAT + 2));
      chk($sformatf("rnd%0d_grant", t), 32'({i_ready, d_ready}), want_d ? 32'h1 : 32'h2);
      if (want_d) begin
        chk($sformatf("rnd%0d_d_err", t), 32'(d_err), 32'(da[1:0] != 2'b00));
        if (dw) ref_write(da, wd, be);
        else    exp_d_rd = ref_mem[da[9:2]];
      end else begin
        exp_i_rd = ref_mem[ia[9:2]];
      end
      chk($sformatf("rnd%0d_i_rdata", t), i_rdata, exp_i_rd);
      chk($sformatf("rnd%0d_d_rdata", t), d_rdata, exp_d_rd);
      last_d = want_d;
      idle_in();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
